// File: rtl/hf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hf_pkg
//  Description : Shared types and default constants for the hazard-function
//                output qualifier and its synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hf_pkg;

  // Qualifier FSM states: two settled levels plus one qualification state
  // for each direction of travel.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } hfState_e;

  // Default build constants.
  localparam int HF_SYNC_STAGES   = 2;
  localparam int HF_STABLE_CYCLES = 4;
  localparam int HF_CNT_W         = 8;

  // Width of a counter that must hold values 0 .. maxVal.
  function automatic int hfCntWidth(input int maxVal);
    int w;
    w = 1;
    while ((1 << w) <= maxVal) w++;
    return w;
  endfunction

endpackage : hf_pkg
`default_nettype wire

// File: rtl/hf_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hf_sync
//  Description : SYNC_STAGES-deep flop chain bringing an asynchronous level
//                into the clk domain. Synchronous active-low reset to 0.
//                Also used for the A..D switch inputs upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf_sync #(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw level through the chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule : hf_sync
`default_nettype wire

// File: rtl/hf_output_qualifier.sv
`default_nettype none
// ============================================================================
//  Module      : hf_output_qualifier
//  Description : Synchronizes the raw hazard-function output F, debounces it
//                with a run-length qualifier, emits a clean level with rise /
//                fall strobes and counts rejected (glitch) transitions.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf_output_qualifier
  import hf_pkg::*;
#(
  parameter int SYNC_STAGES   = HF_SYNC_STAGES,    // >= 2
  parameter int STABLE_CYCLES = HF_STABLE_CYCLES,  // >= 2
  parameter int CNT_W         = HF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_in,
  input  logic             clr_cnt,
  output logic             f_filt,
  output logic             f_rise,
  output logic             f_fall,
  output logic             glitch_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             busy
);

  // The run counter only has to reach STABLE_CYCLES-1.
  localparam int                 c_RUN_W    = hfCntWidth(STABLE_CYCLES - 1);
  localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);
  localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

  logic               w_fS;
  logic               w_glitchEvt;
  hfState_e           r_state;
  logic [c_RUN_W-1:0] r_run;
  logic               r_fFilt;
  logic               r_fRise;
  logic               r_fFall;
  logic               r_glitch;
  logic               r_busy;
  logic [CNT_W-1:0]   r_glitchCnt;

  // --------------------------------------------------------------------------
  // Input synchronizer: the FSM never looks at f_in directly.
  // --------------------------------------------------------------------------
  hf_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (f_in),
    .q     (w_fS)
  );

  // A qualification is aborted when the synchronized level falls back to the
  // settled level before the run completes.
  assign w_glitchEvt = ((r_state == QUAL_HI) && !w_fS) ||
                       ((r_state == QUAL_LO) &&  w_fS);

  // Qualifier FSM with registered level, strobes and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= STABLE_LO;
      r_run    <= '0;
      r_fFilt  <= 1'b0;
      r_fRise  <= 1'b0;
      r_fFall  <= 1'b0;
      r_glitch <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_fRise  <= 1'b0;
      r_fFall  <= 1'b0;
      r_glitch <= 1'b0;

      case (r_state)
        STABLE_LO: begin
          if (w_fS) begin
            // First sample at the new level counts toward the run.
            r_state <= QUAL_HI;
            r_run   <= c_RUN_ONE;
            r_busy  <= 1'b1;
          end
        end

        QUAL_HI: begin
          if (w_fS) begin
            if (r_run == c_RUN_LAST) begin
              r_state <= STABLE_HI;
              r_run   <= '0;
              r_fFilt <= 1'b1;
              r_fRise <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_run <= r_run + c_RUN_ONE;
            end
          end else begin
            r_state  <= STABLE_LO;
            r_run    <= '0;
            r_glitch <= 1'b1;
            r_busy   <= 1'b0;
          end
        end

        STABLE_HI: begin
          if (!w_fS) begin
            r_state <= QUAL_LO;
            r_run   <= c_RUN_ONE;
            r_busy  <= 1'b1;
          end
        end

        QUAL_LO: begin
          if (!w_fS) begin
            if (r_run == c_RUN_LAST) begin
              r_state <= STABLE_LO;
              r_run   <= '0;
              r_fFilt <= 1'b0;
              r_fFall <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_run <= r_run + c_RUN_ONE;
            end
          end else begin
            r_state  <= STABLE_HI;
            r_run    <= '0;
            r_glitch <= 1'b1;
            r_busy   <= 1'b0;
          end
        end

        default: begin
          r_state <= STABLE_LO;
          r_run   <= '0;
          r_fFilt <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear request overrides a same-cycle glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_glitchCnt <= '0;
    end else if (clr_cnt) begin
      r_glitchCnt <= '0;
    end else if (w_glitchEvt && (r_glitchCnt != c_CNT_MAX)) begin
      r_glitchCnt <= r_glitchCnt + CNT_W'(1);
    end
  end

  assign f_filt       = r_fFilt;
  assign f_rise       = r_fRise;
  assign f_fall       = r_fFall;
  assign glitch_pulse = r_glitch;
  assign glitch_cnt   = r_glitchCnt;
  assign busy         = r_busy;

endmodule : hf_output_qualifier
`default_nettype wire

// File: doc/hf_output_qualifier.md
Name: hf_output_qualifier

Overview:
- Downstream stage of the 4-input combinational hazard-function block; consumes its raw output F.
- F can glitch (static hazards) when A..D change. This block synchronizes F into the clk domain, debounces it, emits a clean level plus edge strobes, and counts rejected glitches.
- Output feeds board LEDs and the lab scoreboard.

Parameters:
- SYNC_STAGES, 2, flops in the input synchronizer chain; legal values >= 2.
- STABLE_CYCLES, 4, consecutive synchronized samples at the new level needed to accept a transition; legal values >= 2.
- CNT_W, 8, width of the glitch counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- f_in  input  1  raw F from the combinational stage; asynchronous to clk.
- clr_cnt  input  1  synchronous clear of glitch_cnt; level-sensitive.
- f_filt  output  1  qualified level of F.
- f_rise  output  1  one-cycle strobe when f_filt goes 0->1.
- f_fall  output  1  one-cycle strobe when f_filt goes 1->0.
- glitch_pulse  output  1  one-cycle strobe when a candidate transition is rejected.
- glitch_cnt  output  CNT_W  saturating count of rejected transitions.
- busy  output  1  high while a transition is being qualified.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset:
  - All sync flops = 0; FSM = STABLE_LO; run counter = 0.
  - f_filt = 0, f_rise = 0, f_fall = 0, glitch_pulse = 0, glitch_cnt = 0, busy = 0.
  - Reset asserted mid-qualification or while f_filt = 1 forces these values on the next edge, regardless of f_in. After release, a high f_in requalifies normally and produces f_rise.
- Synchronizer: f_s is the output of stage SYNC_STAGES. The FSM uses only f_s.
- FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO. The run counter is sized for STABLE_CYCLES.
- STABLE_LO:
  - f_s = 1: go to QUAL_HI, run = 1.
  - Otherwise: hold.
- QUAL_HI:
  - f_s = 1 and run = STABLE_CYCLES-1: go to STABLE_HI; f_filt <= 1; f_rise = 1 for that cycle.
  - f_s = 1, other run values: run++.
  - f_s = 0: go to STABLE_LO; glitch_pulse = 1; glitch_cnt increments.
- STABLE_HI and QUAL_LO mirror STABLE_LO and QUAL_HI with polarity swapped. Acceptance gives f_filt <= 0 and f_fall.
- Acceptance therefore needs STABLE_CYCLES consecutive f_s samples at the new level, counting the first.
- Latency: f_in stable before edge 0 -> f_filt changes, with its strobe, on edge SYNC_STAGES+STABLE_CYCLES-1 (6th edge at defaults).
- A pulse on f_s lasting 1..STABLE_CYCLES-1 cycles gives exactly one glitch_pulse and no f_filt change.
- busy = 1 exactly in QUAL_HI and QUAL_LO.
- Strobes are registered, mutually exclusive, and never high for two consecutive cycles.
- glitch_cnt:
  - Saturates at 2^CNT_W-1 with no wrap. glitch_pulse still fires at saturation.
  - clr_cnt = 1 sets it to 0 on the next edge.
  - clr_cnt and a glitch in the same cycle: clear wins (count = 0), glitch_pulse still asserted.
- f_in toggling continuously faster than STABLE_CYCLES: f_filt holds its value and a glitch is counted per aborted qualification.

Decomposition:
- Shared package hf_pkg:
  - state enum (STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO);
  - default constants HF_SYNC_STAGES = 2, HF_STABLE_CYCLES = 4, HF_CNT_W = 8.
- Sub-module hf_sync: parameterized SYNC_STAGES flop chain with synchronous active-low reset to 0. Reused for the A..D switch inputs upstream.
- FSM, run counter and glitch counter stay in hf_output_qualifier.

Test Plan:
- Reset, then f_in = 0 for 20 cycles -> all outputs 0, busy = 0, glitch_cnt = 0.
- f_in 0->1 held -> f_rise and f_filt = 1 on the 6th edge after the change; busy high for the preceding 3 cycles; glitch_cnt = 0.
- From f_filt = 1, f_in low for 2 cycles then high -> one glitch_pulse, f_filt stays 1, glitch_cnt = 1, no f_fall.
- 300 one-cycle-high f_in pulses with CNT_W = 8 -> glitch_cnt = 255 (saturated), 300 glitch_pulse strobes, f_filt = 0 throughout.
- glitch_cnt = 5, then clr_cnt asserted in the same cycle as a rejected glitch -> glitch_cnt = 0, glitch_pulse = 1.
- rst_n low for 1 cycle while f_filt = 1 and f_in = 1 -> next edge f_filt = 0, glitch_cnt = 0; after release, f_rise on the 6th edge.
